alu_arbiter: RTL and testbench

//   Shares one 4-bit `alu` instance (3-bit op, 5-bit result) between two requesters.
//   - Round-robin grant; one operation in flight at a time.
//   - Latches the granted operands and op, and holds them on the ALU inputs.
//   - Waits ALU_LATENCY cycles, captures alu_q, returns it with a valid/ready response.
//   - Sits between the host-side command logic and the shared ALU.

---
 rtl/alu_arbiter.sv | 112 +++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 4-bit ALU between two requesters.
// Only one operation is in flight; its operands are held on the ALU until the result is taken.
module alu_arbiter #(
   parameter int ALU_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [5:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic [1:0] resp_valid,
   input  logic [1:0] resp_ready,
   output logic [4:0] resp_q,
   output logic       busy,
   output logic [2:0] alu_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [4:0] alu_q
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   localparam logic [3:0] CntLoad = 4'(ALU_LATENCY - 1);

   state_e     state_q, state_d;
   logic       grant_q, grant_d;
   logic       lastGrant_q, lastGrant_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] aluOp_q, aluOp_d;
   logic [3:0] aluA_q, aluA_d;
   logic [3:0] aluB_q, aluB_d;
   logic [4:0] respQ_q, respQ_d;
   logic       winner;

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      winner = (req_valid == 2'b11) ? ~lastGrant_q : req_valid[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         cnt_q       <= '0;
         aluOp_q     <= '0;
         aluA_q      <= '0;
         aluB_q      <= '0;
         respQ_q     <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         cnt_q       <= cnt_d;
         aluOp_q     <= aluOp_d;
         aluA_q      <= aluA_d;
         aluB_q      <= aluB_d;
         respQ_q     <= respQ_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      cnt_d       = cnt_q;
      aluOp_d     = aluOp_q;
      aluA_d      = aluA_q;
      aluB_d      = aluB_q;
      respQ_d     = respQ_q;
      req_ready   = '0;
      resp_valid  = '0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready[winner] = 1'b1;
               grant_d           = winner;
               lastGrant_d       = winner;
               cnt_d             = CntLoad;
               aluOp_d           = winner ? req_op[5:3] : req_op[2:0];
               aluA_d            = winner ? req_a[7:4]  : req_a[3:0];
               aluB_d            = winner ? req_b[7:4]  : req_b[3:0];
               state_d           = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               respQ_d = alu_q;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign resp_q = respQ_q;
   assign alu_op = aluOp_q;
   assign alu_a  = aluA_q;
   assign alu_b  = aluB_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (latency 1 and 3) driven by directed and random stimulus,
// compared every cycle against a transaction-level model of the arbiter and a behavioural ALU.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst [2];
   logic [1:0] reqValid [2];
   logic [1:0] reqReady [2];
   logic [5:0] reqOp [2];
   logic [7:0] reqA [2];
   logic [7:0] reqB [2];
   logic [1:0] respValid [2];
   logic [1:0] respReady [2];
   logic [4:0] respQ [2];
   logic       busy [2];
   logic [2:0] aluOp [2];
   logic [3:0] aluA [2];
   logic [3:0] aluB [2];
   logic [4:0] aluQ [2];

   int checks = 0;
   int passed = 0;

   // Model of each arbiter: idle flag, cycles since accept, granted side and the latched operation.
   bit         mIdle [2];
   int         mAge [2];
   bit         mG [2];
   bit         mLast [2];
   bit         mZero [2];
   logic [2:0] mOp [2];
   logic [3:0] mA [2];
   logic [3:0] mB [2];
   logic [4:0] mRes [2];

   always #5 clk = ~clk;

   function automatic logic [4:0] aluModel(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b} - 5'd1;
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {a, 1'b0};
         3'd5:    return {2'b00, a[3:1]};
         3'd6:    return {1'b0, ~a};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   assign aluQ[0] = aluModel(aluOp[0], aluA[0], aluB[0]);
   assign aluQ[1] = aluModel(aluOp[1], aluA[1], aluB[1]);

   alu_arbiter #(.ALU_LATENCY(1)) dutLat1 (
      .clk(clk), .rst(rst[0]),
      .req_valid(reqValid[0]), .req_ready(reqReady[0]),
      .req_op(reqOp[0]), .req_a(reqA[0]), .req_b(reqB[0]),
      .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_q(respQ[0]),
      .busy(busy[0]), .alu_op(aluOp[0]), .alu_a(aluA[0]), .alu_b(aluB[0]), .alu_q(aluQ[0])
   );

   alu_arbiter #(.ALU_LATENCY(3)) dutLat3 (
      .clk(clk), .rst(rst[1]),
      .req_valid(reqValid[1]), .req_ready(reqReady[1]),
      .req_op(reqOp[1]), .req_a(reqA[1]), .req_b(reqB[1]),
      .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_q(respQ[1]),
      .busy(busy[1]), .alu_op(aluOp[1]), .alu_a(aluA[1]), .alu_b(aluB[1]), .alu_q(aluQ[1])
   );

   function automatic int lat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Which requester the arbiter should pick right now, or -1 for nobody.
   function automatic int pick(input int d);
      if (reqValid[d] == 2'b11) return mLast[d] ? 0 : 1;
      if (reqValid[d] == 2'b01) return 0;
      if (reqValid[d] == 2'b10) return 1;
      return -1;
   endfunction

   // Advance the model on every rising edge using the inputs the DUT sees at that edge.
   always @(posedge clk) begin : modelUpdate
      int g;
      for (int d = 0; d < 2; d++) begin
         if (rst[d]) begin
            mIdle[d] = 1'b1;
            mLast[d] = 1'b1;
            mZero[d] = 1'b1;
            mAge[d]  = 0;
         end else if (mIdle[d]) begin
            g = pick(d);
            if (g >= 0) begin
               mIdle[d] = 1'b0;
               mAge[d]  = 1;
               mG[d]    = g[0];
               mLast[d] = g[0];
               mZero[d] = 1'b0;
               mOp[d]   = reqOp[d][g*3 +: 3];
               mA[d]    = reqA[d][g*4 +: 4];
               mB[d]    = reqB[d][g*4 +: 4];
               mRes[d]  = aluModel(mOp[d], mA[d], mB[d]);
            end
         end else if (mAge[d] > lat(d)) begin
            if (respReady[d][mG[d]]) mIdle[d] = 1'b1;
         end else begin
            mAge[d]++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic checkAll(input int d);
      int g;
      logic [1:0] expReady;
      logic [1:0] expRv;
      if (rst[d]) return;
      g = pick(d);
      expReady = (mIdle[d] && g >= 0) ? 2'(1 << g) : 2'b00;
      expRv    = (!mIdle[d] && mAge[d] > lat(d)) ? 2'(1 << mG[d]) : 2'b00;
      checkOutput($sformatf("d%0d req_ready", d), reqReady[d], expReady);
      checkOutput($sformatf("d%0d busy", d), busy[d], !mIdle[d]);
      checkOutput($sformatf("d%0d resp_valid", d), respValid[d], expRv);
      if (expRv != 2'b00)
         checkOutput($sformatf("d%0d resp_q", d), respQ[d], mRes[d]);
      if (!mIdle[d]) begin
         checkOutput($sformatf("d%0d alu_op", d), aluOp[d], mOp[d]);
         checkOutput($sformatf("d%0d alu_a", d), aluA[d], mA[d]);
         checkOutput($sformatf("d%0d alu_b", d), aluB[d], mB[d]);
      end else if (mZero[d]) begin
         checkOutput($sformatf("d%0d zero alu", d), {aluOp[d], aluA[d], aluB[d]}, 0);
         checkOutput($sformatf("d%0d zero resp_q", d), respQ[d], 0);
      end
   endtask

   // One clock: check the settled outputs, take the edge, then withdraw any accepted request.
   task automatic tick(input int d);
      logic [1:0] acc;
      #1;
      checkAll(d);
      acc = reqReady[d];
      @(posedge clk);
      #2;
      reqValid[d] = reqValid[d] & ~acc;
   endtask

   task automatic applyStimulus(input int d, input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      reqValid[d][i]     = 1'b1;
      reqOp[d][i*3 +: 3] = op;
      reqA[d][i*4 +: 4]  = a;
      reqB[d][i*4 +: 4]  = b;
   endtask

   task automatic doReset(input int d);
      rst[d]       = 1'b1;
      reqValid[d]  = 2'b00;
      respReady[d] = 2'b00;
      @(posedge clk);
      #2;
      rst[d] = 1'b0;
   endtask

   task automatic waitResp(input int d, input string tag);
      int n = 0;
      while (respValid[d] == 2'b00 && n < 20) begin
         tick(d);
         n++;
      end
      #1;
      checkOutput({tag, " response seen"}, respValid[d] != 2'b00, 1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d]       = 1'b1;
         reqValid[d]  = '0;
         reqOp[d]     = '0;
         reqA[d]      = '0;
         reqB[d]      = '0;
         respReady[d] = '0;
      end
      repeat (2) @(posedge clk);
      #2;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // Reset state
      #1;
      checkOutput("reset busy", busy[0], 0);
      checkOutput("reset resp_valid", respValid[0], 0);
      checkOutput("reset alu", {aluOp[0], aluA[0], aluB[0], respQ[0]}, 0);

      // Single request, latency 1: 7+9
      applyStimulus(0, 0, 3'd0, 4'h7, 4'h9);
      #1;
      checkOutput("t1 ready at T", reqReady[0], 2'b01);
      tick(0);
      #1;
      checkOutput("t1 busy T+1", busy[0], 1);
      checkOutput("t1 resp_valid T+1", respValid[0], 2'b00);
      tick(0);
      #1;
      checkOutput("t1 resp_valid T+2", respValid[0], 2'b01);
      checkOutput("t1 resp_q", respQ[0], 5'h10);
      respReady[0] = 2'b01;
      tick(0);
      #1;
      checkOutput("t1 resp_valid drop", respValid[0], 2'b00);
      respReady[0] = 2'b00;

      // Both valid from reset: requester 0 wins the first tie
      doReset(0);
      applyStimulus(0, 0, 3'd2, 4'hC, 4'hA);
      applyStimulus(0, 1, 3'd7, 4'hF, 4'h5);
      respReady[0] = 2'b11;
      #1;
      checkOutput("t2 first grant", reqReady[0], 2'b01);
      waitResp(0, "t2 a");
      checkOutput("t2 a who", respValid[0], 2'b01);
      checkOutput("t2 a resp_q", respQ[0], 5'h08);
      tick(0);
      waitResp(0, "t2 b");
      checkOutput("t2 b who", respValid[0], 2'b10);
      checkOutput("t2 b resp_q", respQ[0], 5'h0A);
      tick(0);

      // Requester 1 twice in a row, second request queued during RESP
      respReady[0] = 2'b10;
      applyStimulus(0, 1, 3'd1, 4'h3, 4'h5);
      waitResp(0, "t3 a");
      checkOutput("t3 a who", respValid[0], 2'b10);
      checkOutput("t3 a resp_q", respQ[0], 5'h1D);
      applyStimulus(0, 1, 3'd4, 4'h9, 4'h0);
      tick(0);
      #1;
      checkOutput("t3 b grant", reqReady[0], 2'b10);
      waitResp(0, "t3 b");
      checkOutput("t3 b who", respValid[0], 2'b10);
      checkOutput("t3 b resp_q", respQ[0], 5'h12);
      tick(0);

      // Response stalled 5 cycles while both requesters wait; wrong-side ready ignored
      respReady[0] = 2'b00;
      applyStimulus(0, 0, 3'd3, 4'h5, 4'hA);
      waitResp(0, "t4");
      applyStimulus(0, 0, 3'd6, 4'h1, 4'h1);
      applyStimulus(0, 1, 3'd0, 4'h2, 4'h3);
      respReady[0] = 2'b10;
      repeat (5) begin
         #1;
         checkOutput("t4 hold resp_valid", respValid[0], 2'b01);
         checkOutput("t4 hold resp_q", respQ[0], 5'h0F);
         checkOutput("t4 hold alu", {aluOp[0], aluA[0], aluB[0]}, {3'd3, 4'h5, 4'hA});
         checkOutput("t4 hold req_ready", reqReady[0], 2'b00);
         checkOutput("t4 hold busy", busy[0], 1);
         tick(0);
      end
      respReady[0] = 2'b01;
      tick(0);
      #1;
      checkOutput("t4 alternate to req1", reqReady[0], 2'b10);
      respReady[0] = 2'b11;
      repeat (8) tick(0);

      // Reset during EXEC discards the operation
      doReset(0);
      applyStimulus(0, 0, 3'd0, 4'h1, 4'h2);
      tick(0);
      rst[0] = 1'b1;
      tick(0);
      rst[0] = 1'b0;
      #1;
      checkOutput("t5 outputs after reset",
                  {reqReady[0], respValid[0], respQ[0], busy[0], aluOp[0], aluA[0], aluB[0]}, 0);
      repeat (3) tick(0);
      applyStimulus(0, 0, 3'd2, 4'hF, 4'h3);
      applyStimulus(0, 1, 3'd0, 4'h4, 4'h4);
      respReady[0] = 2'b01;
      #1;
      checkOutput("t5 tie after reset", reqReady[0], 2'b01);
      waitResp(0, "t5");
      checkOutput("t5 who", respValid[0], 2'b01);
      checkOutput("t5 resp_q", respQ[0], 5'h03);
      tick(0);
      reqValid[0] = 2'b00;

      // Latency 3 instance: response at T+4
      doReset(1);
      applyStimulus(1, 0, 3'd5, 4'hE, 4'h0);
      #1;
      checkOutput("t6 ready at T", reqReady[1], 2'b01);
      tick(1);
      for (int k = 1; k <= 3; k++) begin
         #1;
         checkOutput($sformatf("t6 resp_valid T+%0d", k), respValid[1], 2'b00);
         checkOutput($sformatf("t6 busy T+%0d", k), busy[1], 1);
         tick(1);
      end
      #1;
      checkOutput("t6 resp_valid T+4", respValid[1], 2'b01);
      checkOutput("t6 resp_q", respQ[1], 5'h07);
      respReady[1] = 2'b01;
      tick(1);
      #1;
      checkOutput("t6 resp_valid drop", respValid[1], 2'b00);

      // Random traffic on both instances against the model
      for (int d = 0; d < 2; d++) begin
         doReset(d);
         repeat (300) begin
            for (int i = 0; i < 2; i++) begin
               if (!reqValid[d][i] || $urandom_range(3) == 0) begin
                  reqValid[d][i] = 1'($urandom_range(1));
                  reqOp[d][i*3 +: 3] = 3'($urandom_range(7));
                  reqA[d][i*4 +: 4]  = 4'($urandom_range(15));
                  reqB[d][i*4 +: 4]  = 4'($urandom_range(15));
               end
            end
            respReady[d] = 2'($urandom_range(3));
            rst[d] = ($urandom_range(63) == 0);
            tick(d);
         end
         rst[d] = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
